// File: rtl/dec_seq.sv
// dec_seq: registered N-to-2^N one-hot decoder with level, pulse and scan sequencing.
// Latency: z, idx, active and wrap reflect load/tick/stop/g one cycle after the sampling edge.
// Backpressure: none; stop > load > tick on every edge, and g blanks z without pausing the sequence.
module dec_seq #(
    parameter int N       = 3,
    parameter int RST_IDX = 0
) (
    input  logic                clk,
    input  logic                resetl,
    input  logic [N-1:0]        sel,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic                tick,
    input  logic                stop,
    input  logic                g,
    output logic [(1<<N)-1:0]   z,
    output logic [N-1:0]        idx,
    output logic                active,
    output logic                wrap
);

    localparam int W = 1 << N;

    typedef enum logic [1:0] {
        M_LEVEL = 2'b00,
        M_PULSE = 2'b01,
        M_SCAN  = 2'b10,
        M_RSVD  = 2'b11
    } mode_t;

    mode_t          mode_r, mode_nx;
    logic [N-1:0]   idx_nx;
    logic           active_nx;
    logic           wrap_nx;
    logic [W-1:0]   z_nx;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            mode_r <= M_LEVEL;
            idx    <= N'(RST_IDX);
            active <= 1'b0;
            wrap   <= 1'b0;
            z      <= '0;
        end else begin
            mode_r <= mode_nx;
            idx    <= idx_nx;
            active <= active_nx;
            wrap   <= wrap_nx;
            z      <= z_nx;
        end
    end

    always_comb begin
        mode_nx   = mode_r;
        idx_nx    = idx;
        active_nx = active;
        wrap_nx   = 1'b0;

        if (stop) begin
            active_nx = 1'b0;
        end else if (load) begin
            idx_nx    = sel;
            mode_nx   = mode_t'(mode);
            active_nx = 1'b1;
        end else if (active) begin
            unique case (mode_r)
                M_PULSE: active_nx = 1'b0;
                M_SCAN: begin
                    if (tick) begin
                        idx_nx  = idx + N'(1);
                        wrap_nx = (idx == '1);
                    end
                end
                default: ; // LEVEL and reserved hold until stop
            endcase
        end
    end

    // Decode the value being written this edge so z tracks idx/active with no extra lag.
    always_comb begin
        z_nx = '0;
        if (active_nx && !g)
            z_nx[idx_nx] = 1'b1;
    end

endmodule

// File: tb/tb_dec_seq.sv
// Directed bench for dec_seq (N=3 and N=4 instances); expectations are queued as
// stimulus is driven and popped when the outputs are sampled one cycle later.
module tb_dec_seq;

    typedef struct packed {
        logic [15:0] z;
        logic [3:0]  idx;
        logic        act;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=3 instance
    logic       resetl3 = 1'b0;
    logic [2:0] sel3    = '0;
    logic [1:0] mode3   = '0;
    logic       load3 = 1'b0, tick3 = 1'b0, stop3 = 1'b0, g3 = 1'b0;
    logic [7:0] z3;
    logic [2:0] idx3;
    logic       act3, wrap3;

    // N=4 instance
    logic        resetl4 = 1'b0;
    logic [3:0]  sel4    = '0;
    logic [1:0]  mode4   = '0;
    logic        load4 = 1'b0, tick4 = 1'b0, stop4 = 1'b0, g4 = 1'b0;
    logic [15:0] z4;
    logic [3:0]  idx4;
    logic        act4, wrap4;

    dec_seq #(.N(3), .RST_IDX(0)) u_d3 (
        .clk(clk), .resetl(resetl3), .sel(sel3), .mode(mode3), .load(load3),
        .tick(tick3), .stop(stop3), .g(g3), .z(z3), .idx(idx3), .active(act3), .wrap(wrap3)
    );

    dec_seq #(.N(4), .RST_IDX(0)) u_d4 (
        .clk(clk), .resetl(resetl4), .sel(sel4), .mode(mode4), .load(load4),
        .tick(tick4), .stop(stop4), .g(g4), .z(z4), .idx(idx4), .active(act4), .wrap(wrap4)
    );

    exp_t sb3[$];
    exp_t sb4[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop3(input string tag);
        exp_t e;
        if (sb3.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb3.pop_front();
            cmp({tag, ".z"},    16'(z3),   e.z);
            cmp({tag, ".idx"},  16'(idx3), 16'(e.idx));
            cmp({tag, ".act"},  16'(act3), 16'(e.act));
            cmp({tag, ".wrap"}, 16'(wrap3), 16'(e.wrap));
        end
    endtask

    task automatic pop4(input string tag);
        exp_t e;
        if (sb4.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb4.pop_front();
            cmp({tag, ".z"},    z4,         e.z);
            cmp({tag, ".idx"},  16'(idx4),  16'(e.idx));
            cmp({tag, ".act"},  16'(act4),  16'(e.act));
            cmp({tag, ".wrap"}, 16'(wrap4), 16'(e.wrap));
        end
    endtask

    // Drive one cycle of N=3 stimulus, queue the expected post-edge outputs, check them.
    task automatic step3(input logic [2:0] s, input logic [1:0] m,
                         input logic ld, input logic tk, input logic sp, input logic gg,
                         input logic [7:0] ez, input logic [2:0] ei,
                         input logic ea, input logic ew, input string tag);
        sel3 = s; mode3 = m; load3 = ld; tick3 = tk; stop3 = sp; g3 = gg;
        sb3.push_back('{z: 16'(ez), idx: 4'(ei), act: ea, wrap: ew});
        @(posedge clk);
        #1;
        pop3(tag);
    endtask

    task automatic step4(input logic [3:0] s, input logic [1:0] m,
                         input logic ld, input logic tk, input logic sp, input logic gg,
                         input logic [15:0] ez, input logic [3:0] ei,
                         input logic ea, input logic ew, input string tag);
        sel4 = s; mode4 = m; load4 = ld; tick4 = tk; stop4 = sp; g4 = gg;
        sb4.push_back('{z: ez, idx: ei, act: ea, wrap: ew});
        @(posedge clk);
        #1;
        pop4(tag);
    endtask

    initial begin
        // Reset state, checked with no stimulus edge in between
        #12;
        sb3.push_back('{z: 16'h0, idx: 4'd0, act: 1'b0, wrap: 1'b0});
        pop3("reset");
        @(posedge clk); #1;
        sb3.push_back('{z: 16'h0, idx: 4'd0, act: 1'b0, wrap: 1'b0});
        pop3("reset_held");
        #3 resetl3 = 1'b1;
        @(posedge clk); #1;

        // LEVEL
        step3(3'd5, 2'b00, 1, 0, 0, 0, 8'h20, 3'd5, 1, 0, "lvl_load");
        for (int i = 0; i < 10; i++)
            step3(3'd0, 2'b10, 0, 1'(i % 2), 0, 0, 8'h20, 3'd5, 1, 0, "lvl_hold");
        step3(3'd0, 2'b00, 0, 0, 1, 0, 8'h00, 3'd5, 0, 0, "lvl_stop");

        // Gate blanks z only
        step3(3'd2, 2'b00, 1, 0, 0, 0, 8'h04, 3'd2, 1, 0, "gate_load");
        for (int i = 0; i < 3; i++)
            step3(3'd0, 2'b00, 0, 0, 0, 1, 8'h00, 3'd2, 1, 0, "gate_hi");
        step3(3'd0, 2'b00, 0, 0, 0, 0, 8'h04, 3'd2, 1, 0, "gate_lo");
        step3(3'd0, 2'b00, 0, 0, 1, 0, 8'h00, 3'd2, 0, 0, "gate_stop");

        // PULSE single and back-to-back
        step3(3'd7, 2'b01, 1, 0, 0, 0, 8'h80, 3'd7, 1, 0, "pulse_on");
        step3(3'd0, 2'b00, 0, 0, 0, 0, 8'h00, 3'd7, 0, 0, "pulse_off");
        step3(3'd0, 2'b00, 0, 1, 0, 0, 8'h00, 3'd7, 0, 0, "pulse_idle");
        step3(3'd1, 2'b01, 1, 0, 0, 0, 8'h02, 3'd1, 1, 0, "train1");
        step3(3'd2, 2'b01, 1, 0, 0, 0, 8'h04, 3'd2, 1, 0, "train2");
        step3(3'd3, 2'b01, 1, 0, 0, 0, 8'h08, 3'd3, 1, 0, "train3");
        step3(3'd0, 2'b00, 0, 0, 0, 0, 8'h00, 3'd3, 0, 0, "train_end");

        // Reserved mode behaves as LEVEL
        step3(3'd4, 2'b11, 1, 0, 0, 0, 8'h10, 3'd4, 1, 0, "rsvd_load");
        step3(3'd0, 2'b10, 0, 1, 0, 0, 8'h10, 3'd4, 1, 0, "rsvd_tick");

        // SCAN with wrap and freeze (tick on the load edge is ignored)
        step3(3'd6, 2'b10, 1, 1, 0, 0, 8'h40, 3'd6, 1, 0, "scan_load");
        step3(3'd0, 2'b00, 0, 1, 0, 0, 8'h80, 3'd7, 1, 0, "scan_7");
        step3(3'd0, 2'b00, 0, 1, 0, 0, 8'h01, 3'd0, 1, 1, "scan_wrap");
        step3(3'd0, 2'b00, 0, 1, 0, 0, 8'h02, 3'd1, 1, 0, "scan_1");
        step3(3'd0, 2'b00, 0, 0, 0, 0, 8'h02, 3'd1, 1, 0, "scan_frz0");
        step3(3'd0, 2'b00, 0, 0, 0, 0, 8'h02, 3'd1, 1, 0, "scan_frz1");

        // Priority
        step3(3'd5, 2'b10, 1, 1, 1, 0, 8'h00, 3'd1, 0, 0, "prio_stop");
        step3(3'd3, 2'b10, 1, 1, 0, 0, 8'h08, 3'd3, 1, 0, "prio_load");
        step3(3'd0, 2'b00, 0, 1, 0, 1, 8'h00, 3'd4, 1, 0, "scan_gated");
        step3(3'd0, 2'b00, 0, 1, 0, 0, 8'h20, 3'd5, 1, 0, "scan_5");

        // Async reset between edges
        #3 resetl3 = 1'b0;
        #1;
        sb3.push_back('{z: 16'h0, idx: 4'd0, act: 1'b0, wrap: 1'b0});
        pop3("async_rst");
        tick3 = 1'b0;
        @(posedge clk); #3 resetl3 = 1'b1;

        // N=4 scan wrap
        #3 resetl4 = 1'b1;
        @(posedge clk); #1;
        step4(4'd15, 2'b10, 1, 0, 0, 0, 16'h8000, 4'd15, 1, 0, "n4_load");
        step4(4'd0,  2'b00, 0, 1, 0, 0, 16'h0001, 4'd0,  1, 1, "n4_wrap");
        step4(4'd0,  2'b00, 0, 1, 0, 0, 16'h0002, 4'd1,  1, 0, "n4_step");
        step4(4'd0,  2'b00, 0, 0, 1, 0, 16'h0000, 4'd1,  0, 0, "n4_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_seq.md
Name: dec_seq

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with active-low output gate g.
- Adds a sequencing engine: level hold, single-cycle pulse, and auto-advancing scan mode.
- Generates chip-select and strobe sequences for memory, register-bank and bus-slot selection in the object and blitter datapaths.
- Replaces fixed 3-to-8 decoders wherever the select must be held, pulsed or stepped.

Parameters:
- N, 3, select width; output width is 2^N (N from 1 to 6).
- RST_IDX, 0, idx value loaded at reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetl  input  1  asynchronous active-low reset.
- sel  input  N  select index captured on load.
- mode  input  2  operating mode captured on load: 00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved (treated as LEVEL).
- load  input  1  start or restart the sequence with sel and mode.
- tick  input  1  advance strobe; used in SCAN mode only.
- stop  input  1  terminate the sequence; active clears.
- g  input  1  active-low output gate, as on existing decoders.
- z  output  2^N  registered one-hot select.
- idx  output  N  current index register.
- active  output  1  sequence in progress.
- wrap  output  1  one-cycle pulse when SCAN rolls over from 2^N-1 to 0.

Behaviour:
- Reset (resetl low, asynchronous): z=0, idx=RST_IDX, active=0, wrap=0, stored mode=LEVEL. The block is held in this state while resetl is low and leaves it on the first clk edge after release.
- Internal state: idx, active, mode_r (mode captured on load). mode changes while not loading have no effect.
- Priority per edge: stop > load > tick.
- stop=1: active<=0; idx holds; wrap<=0.
- load=1 (stop=0): idx<=sel; mode_r<=mode; active<=1. This restarts any sequence in progress, including mid-PULSE and mid-SCAN. tick in the same cycle is ignored.
- LEVEL: active stays 1 until stop. tick is ignored.
- PULSE: active goes 1 on the load edge and is forced 0 on the following edge unless a new load occurs. Back-to-back loads give a continuous pulse train, one index per cycle.
- SCAN (active=1, no load/stop): on each tick=1, idx<=idx+1 modulo 2^N.
  - wrap<=1 exactly when idx=2^N-1 and it advances to 0; otherwise wrap<=0.
  - tick=0 holds idx.
  - Scan runs indefinitely until stop.
- Output register: z<=onehot(idx_next) when active_next=1 and g=0, else z<=0, where idx_next and active_next are the values being written on the same edge.
  - Result: z reflects load, tick and stop exactly one cycle after the sampling edge.
  - g is sampled and also has one cycle of latency.
  - g=1 blanks z only; idx, active and the sequence continue to advance.
- z is always zero or exactly one-hot; it never has more than one bit set.
- wrap is independent of g.
- idx and active outputs are the register values directly.

Test Plan:
- Reset then N=3, LEVEL: assert resetl, release; load sel=5 mode=00, g=0 -> next cycle z=8'h20, idx=5, active=1; holds for 10 cycles with tick toggling; stop -> next cycle z=0, active=0, idx=5.
- Gate: LEVEL sel=2 active, raise g for 3 cycles -> z=0 for those 3 cycles, delayed by one cycle; idx=2 and active=1 throughout; g low -> z=8'h04 one cycle later.
- PULSE:
  - load sel=7 mode=01 -> z=8'h80 for exactly one cycle, then z=0, active=0.
  - Loads with sel=1,2,3 on consecutive cycles -> z=02,04,08 on consecutive cycles.
- SCAN wrap: load sel=6 mode=10, tick every cycle -> z=40,80,01,02; wrap=1 only in the cycle z=01 (idx=0); tick held low 2 cycles -> z and idx frozen.
- Priority: during SCAN assert stop, load and tick together -> active=0, z=0, idx unchanged. Assert load and tick with sel=3 -> idx=3, not 4.
- Async reset mid-scan, then N=4 instance:
  - pull resetl low between clock edges -> z=0, active=0, idx=0 immediately, without a clock edge.
  - N=4 SCAN from sel=15 -> z=16'h8000 then 16'h0001 with wrap=1.
